// File: rtl/move_capture.sv
// Two-player input stage: synchronizes and edge-detects raw buttons, captures one
// action per player per turn and releases both as simultaneous single-cycle pulses.
module move_capture #(
    parameter int unsigned TURN_CYCLES = 8,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [5:0] btn1,
    input  logic [5:0] btn2,
    output logic       punch1_o,
    output logic       kick1_o,
    output logic       wait1_o,
    output logic       jump1_o,
    output logic       left1_o,
    output logic       right1_o,
    output logic       punch2_o,
    output logic       kick2_o,
    output logic       wait2_o,
    output logic       jump2_o,
    output logic       left2_o,
    output logic       right2_o,
    output logic       turn_strobe,
    output logic       pending1,
    output logic       pending2,
    output logic       dropped1,
    output logic       dropped2,
    output logic [3:0] turn_count
);

    localparam int unsigned CMAX = (TURN_CYCLES > GAP_CYCLES) ? TURN_CYCLES : GAP_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX) + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, GAP} state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt, cnt_n;
    logic [5:0]    s1a, s1b, h1, s2a, s2b, h2;
    logic [5:0]    rise1, rise2;
    logic [2:0]    slot1, slot2, slot1_n, slot2_n;
    logic          pend1, pend2, pend1_n, pend2_n;
    logic [5:0]    act1, act2, act1_n, act2_n;
    logic          drop1, drop2, drop1_n, drop2_n;
    logic [3:0]    tcnt, tcnt_n;

    // Slot code is the button bit index, so lowest set bit gives the priority order.
    function automatic logic [2:0] prio(input logic [5:0] r);
        logic [2:0] code;
        logic       found;
        code  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (r[i] && !found) begin
                code  = 3'(i);
                found = 1'b1;
            end
        end
        return code;
    endfunction

    // An empty slot commits as wait (bit 5).
    function automatic logic [5:0] decode(input logic p, input logic [2:0] c);
        return p ? (6'd1 << c) : 6'b100000;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1a <= '0; s1b <= '0; h1 <= '0;
            s2a <= '0; s2b <= '0; h2 <= '0;
        end else begin
            s1a <= btn1; s1b <= s1a; h1 <= s1b;
            s2a <= btn2; s2b <= s2a; h2 <= s2b;
        end
    end

    assign rise1 = s1b & ~h1;
    assign rise2 = s2b & ~h2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            slot1 <= '0;
            slot2 <= '0;
            pend1 <= 1'b0;
            pend2 <= 1'b0;
            act1  <= '0;
            act2  <= '0;
            drop1 <= 1'b0;
            drop2 <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= nstate;
            cnt   <= cnt_n;
            slot1 <= slot1_n;
            slot2 <= slot2_n;
            pend1 <= pend1_n;
            pend2 <= pend2_n;
            act1  <= act1_n;
            act2  <= act2_n;
            drop1 <= drop1_n;
            drop2 <= drop2_n;
            tcnt  <= tcnt_n;
        end
    end

    always_comb begin
        nstate  = state;
        cnt_n   = cnt;
        slot1_n = slot1;
        slot2_n = slot2;
        pend1_n = pend1;
        pend2_n = pend2;
        act1_n  = '0;
        act2_n  = '0;
        drop1_n = 1'b0;
        drop2_n = 1'b0;
        tcnt_n  = tcnt;
        case (state)
            IDLE: begin
                if (en) begin
                    nstate = COLLECT;
                    cnt_n  = '0;
                end
            end
            COLLECT: begin
                cnt_n = cnt + 1'b1;
                if (!en) begin
                    nstate  = IDLE;
                    slot1_n = '0;
                    slot2_n = '0;
                    pend1_n = 1'b0;
                    pend2_n = 1'b0;
                end else begin
                    if (|rise1) begin
                        if (!pend1) begin
                            slot1_n = prio(rise1);
                            pend1_n = 1'b1;
                        end else begin
                            drop1_n = 1'b1;
                        end
                    end
                    if (|rise2) begin
                        if (!pend2) begin
                            slot2_n = prio(rise2);
                            pend2_n = 1'b1;
                        end else begin
                            drop2_n = 1'b1;
                        end
                    end
                    // A capture on the timeout edge still makes it into this turn.
                    if ((pend1 && pend2) || (cnt == CW'(TURN_CYCLES - 1))) begin
                        nstate = COMMIT;
                        act1_n = decode(pend1_n, slot1_n);
                        act2_n = decode(pend2_n, slot2_n);
                    end
                end
            end
            COMMIT: begin
                slot1_n = '0;
                slot2_n = '0;
                pend1_n = 1'b0;
                pend2_n = 1'b0;
                tcnt_n  = tcnt + 1'b1;
                cnt_n   = '0;
                nstate  = en ? GAP : IDLE;
            end
            GAP: begin
                cnt_n = cnt + 1'b1;
                if (!en) begin
                    nstate = IDLE;
                end else if (cnt == CW'(GAP_CYCLES - 1)) begin
                    nstate = COLLECT;
                    cnt_n  = '0;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    assign {wait1_o, right1_o, left1_o, jump1_o, kick1_o, punch1_o} = act1;
    assign {wait2_o, right2_o, left2_o, jump2_o, kick2_o, punch2_o} = act2;
    assign turn_strobe = (state == COMMIT);
    assign pending1    = pend1;
    assign pending2    = pend2;
    assign dropped1    = drop1;
    assign dropped2    = drop2;
    assign turn_count  = tcnt;

endmodule
